// File: rtl/seg_pkg.sv
// Shared types and active-low segment patterns for the seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Bit order {dp,g,f,e,d,c,b,a}, active-low
    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

endpackage

// File: rtl/seg_bcd_decoder.sv
// Combinational BCD nibble + decimal point to active-low segment pattern.
// blank forces all segments off while still honouring the decimal point.
module seg_bcd_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] base;

    always_comb begin
        base = SEG_DASH;
        unique case (nibble)
            4'd0:    base = SEG_0;
            4'd1:    base = SEG_1;
            4'd2:    base = SEG_2;
            4'd3:    base = SEG_3;
            4'd4:    base = SEG_4;
            4'd5:    base = SEG_5;
            4'd6:    base = SEG_6;
            4'd7:    base = SEG_7;
            4'd8:    base = SEG_8;
            4'd9:    base = SEG_9;
            default: base = SEG_DASH;
        endcase
        if (blank)
            base = SEG_OFF;
        seg = {base[7] & ~dp, base[6:0]};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin 4-digit seven-segment scanner with blanking gap and frame-aligned double buffer.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [7:0]  sevenSegment,
    output logic [3:0]  anode,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST       = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam scan_state_t   RST_STATE  = (BLANK_CYC == 0) ? SHOW : BLANK;

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    scan_state_t   state, state_nx;
    logic [15:0]   shadow_dig, shadow_dig_nx, pend_dig;
    logic [3:0]    shadow_dp, shadow_dp_nx, pend_dp;
    logic          pend_valid;
    logic          wrap, boundary, ack_nx;
    logic [3:0]    cur_nib;
    logic          cur_dp, lz;
    logic [7:0]    dec_seg;

    always_comb begin
        wrap     = (cnt == LAST);
        boundary = wrap && (idx == 2'd3);
        cnt_nx   = wrap ? '0 : cnt + 1'b1;
        idx_nx   = wrap ? idx + 2'd1 : idx;

        state_nx = state;
        unique case (state)
            BLANK: if (cnt == BLANK_LAST) state_nx = SHOW;
            SHOW:  if (wrap && (BLANK_CYC != 0)) state_nx = BLANK;
            default: state_nx = RST_STATE;
        endcase

        // A load coinciding with the boundary is newer than anything pending, so it wins
        shadow_dig_nx = shadow_dig;
        shadow_dp_nx  = shadow_dp;
        ack_nx        = 1'b0;
        if (boundary) begin
            if (load) begin
                shadow_dig_nx = digits_in;
                shadow_dp_nx  = dp_in;
                ack_nx        = 1'b1;
            end else if (pend_valid) begin
                shadow_dig_nx = pend_dig;
                shadow_dp_nx  = pend_dp;
                ack_nx        = 1'b1;
            end
        end

        cur_nib = shadow_dig_nx[{idx_nx, 2'b00} +: 4];
        cur_dp  = shadow_dp_nx[idx_nx];
    end

`ifdef SEG_LZ_BLANK_EN
    always_comb begin
        lz = 1'b0;
        unique case (idx_nx)
            2'd1:    lz = (shadow_dig_nx[15:4]  == '0);
            2'd2:    lz = (shadow_dig_nx[15:8]  == '0);
            2'd3:    lz = (shadow_dig_nx[15:12] == '0);
            default: lz = 1'b0;
        endcase
    end
`else
    assign lz = 1'b0;
`endif

    seg_bcd_decoder u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (lz),
        .seg    (dec_seg)
    );

    // Outputs are registered from next-state values so they line up with the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            state        <= RST_STATE;
            shadow_dig   <= '0;
            shadow_dp    <= '0;
            pend_dig     <= '0;
            pend_dp      <= '0;
            pend_valid   <= 1'b0;
            load_ack     <= 1'b0;
            frame_tick   <= 1'b0;
            anode        <= '1;
            sevenSegment <= SEG_OFF;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            state      <= state_nx;
            shadow_dig <= shadow_dig_nx;
            shadow_dp  <= shadow_dp_nx;
            if (boundary) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_dig   <= digits_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
            load_ack   <= ack_nx;
            frame_tick <= boundary;
            if (state_nx == SHOW) begin
                anode        <= ~(4'b0001 << idx_nx);
                sevenSegment <= dec_seg;
            end else begin
                anode        <= '1;
                sevenSegment <= SEG_OFF;
            end
        end
    end

endmodule
